stream_arb_2x1: RTL
===================

STREAM_ARB_2X1 -- requirements
Module: stream_arb_2x1

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of a_data, b_data and y_data.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of each grant counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 a_valid  input  1  SHALL indicate that source A offers a_data.
REQ-006 a_data  input  WIDTH  SHALL be the payload from source A.
REQ-007 a_ready  output  1  SHALL indicate that A's word is accepted this cycle.
REQ-008 b_valid  input  1  SHALL indicate that source B offers b_data.
REQ-009 b_data  input  WIDTH  SHALL be the payload from source B.
REQ-010 b_ready  output  1  SHALL indicate that B's word is accepted this cycle.
REQ-011 y_valid  output  1  SHALL indicate that the output register holds a word.
REQ-012 y_data  output  WIDTH  SHALL be the registered output word.
REQ-013 y_ready  input  1  SHALL indicate that the sink consumes y_data this cycle.
REQ-014 sel  output  1  SHALL give the source of the word in y_data (0=A, 1=B), the select for the downstream 2:1 mux.
REQ-015 a_cnt, b_cnt  output  CNT_W each  SHALL be the saturating grant counts per source.

Function
REQ-016 A transfer SHALL occur on any port when valid and ready are both high at a rising clk edge.
REQ-017 Accept condition acc SHALL equal (!y_valid || y_ready): an empty output register, or one drained this cycle.
REQ-018 The round-robin pointer prio SHALL select the winner on contention: 0 -> A, 1 -> B.
REQ-019 Grant SHALL be: if only one source is valid, that source; if both are valid, the source named by prio; if neither is valid, no grant.
REQ-020 a_ready SHALL be acc && grant==A, and b_ready SHALL be acc && grant==B, combinationally; at most one SHALL be high.
REQ-021 On a grant with acc, the next cycle SHALL have y_valid=1, y_data = the granted data, sel = the granted source, and prio = the non-granted source.
REQ-022 With y_ready=1 and no grant, the next cycle SHALL have y_valid=0, with y_data and sel held.
REQ-023 With y_valid=1 and y_ready=0, y_data, sel and y_valid SHALL hold, and both readies SHALL be 0.
REQ-024 Simultaneous drain and grant SHALL sustain one word per cycle; latency from input transfer to y_valid SHALL be 1 cycle.
REQ-025 prio SHALL change only on a grant.
REQ-026 On each grant, the granted source's counter SHALL increment by 1 and SHALL saturate at all-ones without wrapping.
REQ-027 y_valid SHALL never drop while y_ready=0, and y_data SHALL never change while y_valid=1 && y_ready=0.

Reset
REQ-028 While rst=1, all outputs SHALL take these values immediately, independent of clk: y_valid=0, y_data=0, sel=0, prio=0, a_cnt=0, b_cnt=0.
REQ-029 While rst=1, a_ready and b_ready SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word with no output transfer.
REQ-031 After rst deasserts, the first contended grant SHALL go to A.

Verification
REQ-032 Reset: assert rst asynchronously between edges with y_valid=1 -> y_valid=0, sel=0, a_cnt=b_cnt=0 before the next edge.
REQ-033 Single source: a_valid=1 with a_data=0x11,0x22,0x33, b_valid=0, y_ready=1 -> y_data 0x11,0x22,0x33 on consecutive cycles; sel=0; a_cnt=3.
REQ-034 Contention: a_valid=b_valid=1 (A=0xAA, B=0xBB) held 4 cycles, y_ready=1 -> y_data AA,BB,AA,BB; sel 0,1,0,1; a_cnt=b_cnt=2.
REQ-035 Backpressure: y_ready=0 for 3 cycles with y_valid=1 -> y_data stable, a_ready=b_ready=0; on y_ready=1, the next word is accepted the same cycle.
REQ-036 Saturation: CNT_W=2, 5 A-only grants -> a_cnt=3, no wrap.
REQ-037 Idle drain: y_ready=1 with no valid source -> y_valid=0 next cycle, and prio is unchanged.

Source files
------------

// File: rtl/stream_arb_2x1.sv
//------------------------------------------------------------------------------
// Module      : stream_arb_2x1
// Description : Two-source valid/ready stream arbiter with a registered output
//               stage, round-robin tie-break and saturating per-source grant
//               counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_arb_2x1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;
  logic             r_sel;
  logic             r_prio;
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;

  logic w_acc;
  logic w_grant_a;
  logic w_grant_b;
  logic w_take_a;
  logic w_take_b;

  // Grant decode: a lone valid source wins outright; on contention the
  // round-robin pointer decides (0 -> A, 1 -> B). The output register can
  // accept when it is empty or being drained this cycle.
  always_comb begin
    w_acc     = !r_y_valid || y_ready;
    w_grant_a = a_valid && (!b_valid || !r_prio);
    w_grant_b = b_valid && (!a_valid ||  r_prio);
    w_take_a  = w_acc && w_grant_a && !rst;
    w_take_b  = w_acc && w_grant_b && !rst;
  end

  assign a_ready = w_take_a;
  assign b_ready = w_take_b;

  // Output register and round-robin pointer: load on a grant, go empty on
  // an idle drain, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_sel     <= 1'b0;
      r_prio    <= 1'b0;
    end else if (w_take_a) begin
      r_y_valid <= 1'b1;
      r_y_data  <= a_data;
      r_sel     <= 1'b0;
      r_prio    <= 1'b1;
    end else if (w_take_b) begin
      r_y_valid <= 1'b1;
      r_y_data  <= b_data;
      r_sel     <= 1'b1;
      r_prio    <= 1'b0;
    end else if (w_acc) begin
      r_y_valid <= 1'b0;
    end
  end

  // Per-source grant counters, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_take_a && !(&r_a_cnt)) r_a_cnt <= r_a_cnt + c_cnt_one;
      if (w_take_b && !(&r_b_cnt)) r_b_cnt <= r_b_cnt + c_cnt_one;
    end
  end

  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;
  assign sel     = r_sel;
  assign a_cnt   = r_a_cnt;
  assign b_cnt   = r_b_cnt;

endmodule

`default_nettype wire
